// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, synchronous imem request, one-entry skid buffer and IF/ID register.
// Handles decode stall without dropping in-flight words, redirect/flush and a halt opcode.
module instruction_fetch #(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         INSTR_WIDTH = 20,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   halted
);

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   pending;
    logic [PC_WIDTH-1:0]    pending_pc;
    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic arrival;
    logic ifid_load;
    logic halt_seen;

    // Blocking on pending while stalled guarantees at most one word ever needs the skid.
    assign imem_en = !reset && !halted && !redirect && !skid_valid &&
                     !(stall && instr_valid && pending);
    assign imem_addr = fetch_pc;

    assign arrival   = pending && !halted && !redirect;
    assign ifid_load = !instr_valid || !stall;
    assign halt_seen = arrival && (imem_data[INSTR_WIDTH-1 -: 4] == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            pending     <= 1'b0;
            pending_pc  <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            pending     <= 1'b0;
            skid_valid  <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (imem_en) begin
                pending    <= 1'b1;
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 1'b1;
            end else begin
                pending <= 1'b0;
            end

            if (ifid_load) begin
                if (skid_valid) begin
                    instruction <= skid_instr;
                    instr_pc    <= skid_pc;
                    instr_valid <= 1'b1;
                    skid_valid  <= 1'b0;
                end else if (arrival) begin
                    instruction <= imem_data;
                    instr_pc    <= pending_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end else if (arrival) begin
                skid_instr <= imem_data;
                skid_pc    <= pending_pc;
                skid_valid <= 1'b1;
            end

            if (halt_seen) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall/skid, redirect, halt, PC wrap, async reset.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data = '0;
    logic [19:0] instruction;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;

    logic        imem_en2;
    logic [7:0]  imem_addr2;
    logic [19:0] imem_data2 = '0;
    logic [19:0] instruction2;
    logic [7:0]  instr_pc2;
    logic        instr_valid2;
    logic        halted2;

    logic        halt_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    instruction_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(20), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .halted(halted)
    );

    instruction_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(20), .RESET_PC(8'hFE)) dut_wrap (
        .clock(clock), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(8'h00), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_data(imem_data2), .instruction(instruction2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .halted(halted2)
    );

    // Memory word for address a is 20'h00a0, except the halt word at 5 when enabled.
    always @(posedge clock) begin
        if (imem_en)
            imem_data <= (halt_en && imem_addr == 8'h05) ? 20'hF0000 : {8'h00, imem_addr, 4'h0};
        if (imem_en2)
            imem_data2 <= {8'h00, imem_addr2, 4'h0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] pc);
        check({tag, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        reset = 1'b0;
        #1;
        check("first_issue_en", 32'(imem_en), 32'd1);
        check("first_issue_addr", 32'(imem_addr), 32'd0);

        // Streaming: E1 issue 0, E2.. deliver 0,1,2; wrap instance delivers FE,FF,00,01
        tick();
        check_out("e1", 1'b0, 8'h00);
        tick();
        check_out("s0", 1'b1, 8'h00);
        check("s0_instr", 32'(instruction), 32'h00000);
        check("w0_pc", 32'(instr_pc2), 32'hFE);
        tick();
        check_out("s1", 1'b1, 8'h01);
        check("w1_pc", 32'(instr_pc2), 32'hFF);
        tick();
        check_out("s2", 1'b1, 8'h02);
        check("s2_instr", 32'(instruction), 32'h00020);
        check("w2_pc", 32'(instr_pc2), 32'h00);

        // Stall three cycles while pc 2 is in IF/ID
        stall = 1'b1;
        #1;
        check("stall_en0", 32'(imem_en), 32'd0);
        tick();
        check("w3_pc", 32'(instr_pc2), 32'h01);
        check("w3_valid", 32'(instr_valid2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_out("hold", 1'b1, 8'h02);
            check("hold_instr", 32'(instruction), 32'h00020);
            check("hold_en", 32'(imem_en), 32'd0);
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        check_out("rel3", 1'b1, 8'h03);
        check("rel3_instr", 32'(instruction), 32'h00030);
        tick();
        check_out("bubble", 1'b0, 8'h00);
        tick();
        check_out("rel4", 1'b1, 8'h04);
        tick();
        check_out("rel5", 1'b1, 8'h05);

        // Fill skid under stall, then redirect to 40
        stall = 1'b1;
        tick();
        check_out("skid_hold", 1'b1, 8'h05);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("redir_en0", 32'(imem_en), 32'd0);
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        check_out("flush", 1'b0, 8'h00);
        #1;
        check("redir_issue_en", 32'(imem_en), 32'd1);
        check("redir_issue_addr", 32'(imem_addr), 32'h40);
        tick();
        check_out("flush2", 1'b0, 8'h00);
        tick();
        check_out("redir40", 1'b1, 8'h40);
        check("redir40_instr", 32'(instruction), 32'h00400);

        // Halt word at 5: restart at 3
        halt_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h03;
        tick();
        redirect = 1'b0;
        tick(); tick();
        check_out("h3", 1'b1, 8'h03);
        tick();
        check_out("h4", 1'b1, 8'h04);
        check("h4_halted", 32'(halted), 32'd0);
        tick();
        check_out("h5", 1'b1, 8'h05);
        check("h5_instr", 32'(instruction), 32'hF0000);
        check("h5_halted", 32'(halted), 32'd1);
        check("h5_en", 32'(imem_en), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("halt_idle", 1'b0, 8'h00);
            check("halt_en0", 32'(imem_en), 32'd0);
            check("halt_stay", 32'(halted), 32'd1);
        end
        redirect = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        check("unhalt", 32'(halted), 32'd0);
        #1;
        check("unhalt_en", 32'(imem_en), 32'd1);
        tick(); tick();
        check_out("r10", 1'b1, 8'h10);
        tick();
        check_out("r11", 1'b1, 8'h11);
        halt_en = 1'b0;

        // Async reset mid-stream while stalled with skid full
        stall = 1'b1;
        tick();
        check_out("pre_rst", 1'b1, 8'h11);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_en", 32'(imem_en), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_pc", 32'(instr_pc), 32'd0);
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check("restart_en", 32'(imem_en), 32'd1);
        check("restart_addr", 32'(imem_addr), 32'd0);
        tick();
        check_out("restart_e1", 1'b0, 8'h00);
        tick();
        check_out("restart0", 1'b1, 8'h00);
        tick();
        check_out("restart1", 1'b1, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the 20-bit pipeline processor: owns the program counter, issues reads to a synchronous instruction memory and holds the IF/ID pipeline register consumed by the decode stage. Supports decode back-pressure (stall) without losing in-flight words, branch/jump redirection with flush, and a halt opcode that stops fetching.

## Interface
- PC_WIDTH, 8, width of program counter and instruction addresses
- INSTR_WIDTH, 20, instruction word width; opcode is bits [19:16]
- RESET_PC, 0, first fetch address after reset
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  decode cannot accept; IF/ID register must hold
- redirect  in  1  taken branch/jump from a later stage; flush and refetch
- redirect_pc  in  PC_WIDTH  new fetch address, sampled when redirect=1
- imem_en  out  1  read request this cycle (combinational)
- imem_addr  out  PC_WIDTH  read address, equals fetch_pc
- imem_data  in  INSTR_WIDTH  read data, valid the cycle after imem_en=1
- instruction  out  INSTR_WIDTH  IF/ID instruction word
- instr_pc  out  PC_WIDTH  address of `instruction`
- instr_valid  out  1  IF/ID register holds a real instruction
- halted  out  1  halt opcode seen; fetching stopped

## Operation
- State: fetch_pc, pending (+pending_pc) = request issued last cycle, one-entry skid buffer (skid_valid, skid_instr, skid_pc), IF/ID register, halted.
- Issue: imem_en = !reset && !halted && !redirect && !skid_valid && !(stall && instr_valid && pending). On issue: pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^PC_WIDTH, wraps to 0). No issue: pending<=0.
- Arrival: when pending=1, imem_data is the word for pending_pc. Discarded if halted=1 or redirect=1.
- IF/ID load when !instr_valid || !stall: source priority skid, then arrival, else instr_valid<=0. When skid supplies, an arrival in the same cycle cannot occur (issue was blocked).
- Arrival not loadable into IF/ID (instr_valid && stall) goes to skid; skid never overflows by construction of issue rule.
- Halt: an accepted arrival with opcode 4'b1111 sets halted<=1; the halt word itself is passed downstream normally. Later arrivals discarded.
- Redirect (highest non-reset priority): fetch_pc<=redirect_pc, instr_valid<=0, skid_valid<=0, pending<=0, halted<=0; no issue that cycle; stall ignored for the flush.
- Reset values: fetch_pc=RESET_PC, pending=0, skid_valid=0, instruction=0, instr_pc=0, instr_valid=0, halted=0; imem_en=0 while reset high.

## Timing
- Fetch-to-IF/ID latency: 2 cycles (issue at t, data at t+1, instr_valid at t+2 edge output).
- Steady state without stall: one instruction per cycle.
- Redirect at cycle t: issue of redirect_pc at t+1, its instruction valid in IF/ID after t+2; two bubbles.
- Stall release with skid full: skid drains first cycle, issue resumes that cycle+1; one bubble after release.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; first issue of RESET_PC on first cycle with reset low.

## Test plan
- Reset release, imem holds addr i = 20'h0_0i0 +i, no stall -> instr_pc 0,1,2,3 on consecutive cycles from cycle 2, instr_valid held 1.
- Stall 3 cycles while instr_pc=2 valid -> instruction/instr_pc stay at 2, skid holds 3, imem_en 0; after release sequence 3,4,5 with exactly one bubble, no loss or duplicate.
- redirect=1, redirect_pc=8'h40 while skid full and stalled -> instr_valid 0 next cycle, skid cleared, next valid instr_pc=8'h40 two cycles later.
- Halt word 20'hF0000 at addr 5 -> delivered with instr_pc 5, halted=1, addr 6 never delivered, imem_en stays 0; redirect to 8'h10 clears halted and resumes.
- RESET_PC=8'hFE -> delivered pcs FE, FF, 00, 01 (wrap).
- Assert reset asynchronously mid-stream with stall=1 -> instr_valid, halted, imem_en drop without clock edge; restart from RESET_PC.
